// File: rtl/vending_controller.sv
// Vending controller: N products, M coin types, per-product stock with
// restock, cancel/refund, payment timeout and handshaked change return.
// Ports:
//   clk, reset (async, active-high)
//   sel_valid/sel_index         product selection strobe
//   coin_valid/coin_index       coin acceptor strobe
//   cancel                      refund request
//   item_dispensed              motor-complete sensor
//   change_ack                  payout unit took the change
//   restock_valid/_index/_qty   add stock to one product
//   lcd_display, status_led     one-hot state indication
//   motor_control               one-hot motor drive
//   credit                      collected credit
//   change_valid/change_amount  change handshake
//   coin_reject                 one-cycle pulse, coin returned
//   stock_empty                 per-product empty flags
module vending_controller #(
   parameter int NUM_PRODUCTS   = 4,
   parameter int NUM_COINS      = 4,
   parameter int CREDIT_W       = 8,
   parameter int STOCK_W        = 4,
   parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICE_LIST =
      {8'd150, 8'd100, 8'd75, 8'd50},
   parameter logic [NUM_COINS*CREDIT_W-1:0] COIN_LIST =
      {8'd100, 8'd50, 8'd20, 8'd10},
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int INIT_STOCK     = 5,
   localparam int PIW = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1,
   localparam int CIW = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    sel_valid,
   input  logic [PIW-1:0]          sel_index,
   input  logic                    coin_valid,
   input  logic [CIW-1:0]          coin_index,
   input  logic                    cancel,
   input  logic                    item_dispensed,
   input  logic                    change_ack,
   input  logic                    restock_valid,
   input  logic [PIW-1:0]          restock_index,
   input  logic [STOCK_W-1:0]      restock_qty,
   output logic [7:0]              lcd_display,
   output logic [NUM_PRODUCTS-1:0] motor_control,
   output logic [3:0]              status_led,
   output logic [CREDIT_W-1:0]     credit,
   output logic                    change_valid,
   output logic [CREDIT_W-1:0]     change_amount,
   output logic                    coin_reject,
   output logic [NUM_PRODUCTS-1:0] stock_empty
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CREDIT_W-1:0] CMAX = '1;
   localparam logic [STOCK_W:0] SMAX = {1'b0, {STOCK_W{1'b1}}};

   typedef enum logic [2:0] {
      S_IDLE, S_PAY, S_DISP, S_CHG, S_ERR
   } state_t;

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [PIW-1:0]      idx_q, idx_d;
   logic [TW-1:0]       tmo_q, tmo_d;
   logic [3:0]          err_q, err_d;
   logic [CREDIT_W-1:0] chg_q, chg_d;
   logic                rej_q, rej_d;
   logic [STOCK_W-1:0]  stock_q [NUM_PRODUCTS];
   logic [STOCK_W-1:0]  stock_d [NUM_PRODUCTS];

   logic [CREDIT_W-1:0] price, coin_val, coin_sum, pay_credit;
   logic [CREDIT_W:0]   sum_w;
   logic [STOCK_W-1:0]  sel_stock;
   logic                coin_hit, sel_hit, coin_acc;

   // Table lookups as loops so out-of-range indices never
   // part-select past the end of the packed lists.
   always_comb begin
      price     = '0;
      coin_val  = '0;
      coin_hit  = 1'b0;
      sel_hit   = 1'b0;
      sel_stock = '0;
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
         if (idx_q == PIW'(i))
            price = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
         if (sel_index == PIW'(i)) begin
            sel_hit   = 1'b1;
            sel_stock = stock_q[i];
         end
      end
      for (int i = 0; i < NUM_COINS; i++) begin
         if (coin_index == CIW'(i)) begin
            coin_hit = 1'b1;
            coin_val = COIN_LIST[i*CREDIT_W +: CREDIT_W];
         end
      end
   end

   assign sum_w    = {1'b0, credit_q} + {1'b0, coin_val};
   assign coin_sum = sum_w[CREDIT_W] ? CMAX : sum_w[CREDIT_W-1:0];
   assign coin_acc = coin_valid && coin_hit;
   assign pay_credit = coin_acc ? coin_sum : credit_q;

   // Stock: restock and dispense may hit the same product in one
   // cycle; both apply, then the result saturates.
   always_comb begin
      logic [STOCK_W:0] s;
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
         s = {1'b0, stock_q[i]};
         if (restock_valid && restock_index == PIW'(i))
            s = s + {1'b0, restock_qty};
         if (state_q == S_DISP && item_dispensed &&
             idx_q == PIW'(i) && s != '0)
            s = s - 1'b1;
         if (s > SMAX)
            s = SMAX;
         stock_d[i] = s[STOCK_W-1:0];
      end
   end

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      idx_d    = idx_q;
      tmo_d    = tmo_q;
      err_d    = err_q;
      chg_d    = chg_q;
      rej_d    = coin_valid && !(state_q == S_PAY && coin_hit);
      unique case (state_q)
         S_IDLE: begin
            if (sel_valid) begin
               if (sel_hit && sel_stock != '0) begin
                  state_d = S_PAY;
                  idx_d   = sel_index;
                  tmo_d   = '0;
               end else begin
                  state_d = S_ERR;
                  err_d   = '0;
               end
            end
         end
         S_ERR: begin
            if (err_q == 4'd15)
               state_d = S_IDLE;
            else
               err_d = err_q + 4'd1;
         end
         S_PAY: begin
            // Priority: cancel, then the price check on the
            // registered credit, then coin, then idle timeout.
            if (cancel) begin
               credit_d = pay_credit;
               if (pay_credit == '0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_CHG;
                  chg_d   = pay_credit;
               end
            end else if (credit_q >= price) begin
               state_d  = S_DISP;
               credit_d = pay_credit;
            end else if (coin_acc) begin
               credit_d = pay_credit;
               tmo_d    = '0;
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
               if (credit_q == '0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_CHG;
                  chg_d   = credit_q;
               end
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_DISP: begin
            if (item_dispensed) begin
               credit_d = '0;
               if (credit_q != price) begin
                  state_d = S_CHG;
                  chg_d   = credit_q - price;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_CHG: begin
            if (change_ack) begin
               state_d  = S_IDLE;
               credit_d = '0;
               chg_d    = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         credit_q <= '0;
         idx_q    <= '0;
         tmo_q    <= '0;
         err_q    <= '0;
         chg_q    <= '0;
         rej_q    <= 1'b0;
         for (int i = 0; i < NUM_PRODUCTS; i++)
            stock_q[i] <= STOCK_W'(INIT_STOCK);
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         idx_q    <= idx_d;
         tmo_q    <= tmo_d;
         err_q    <= err_d;
         chg_q    <= chg_d;
         rej_q    <= rej_d;
         for (int i = 0; i < NUM_PRODUCTS; i++)
            stock_q[i] <= stock_d[i];
      end
   end

   always_comb begin
      lcd_display   = 8'h01;
      status_led    = 4'b0000;
      motor_control = '0;
      unique case (state_q)
         S_IDLE: begin
            lcd_display = 8'h01;
            status_led  = 4'b0000;
         end
         S_PAY: begin
            lcd_display = 8'h04;
            status_led  = 4'b0010;
         end
         S_DISP: begin
            lcd_display = 8'h08;
            status_led  = 4'b0100;
            motor_control[idx_q] = 1'b1;
         end
         S_CHG: begin
            lcd_display = 8'h20;
            status_led  = 4'b0001;
         end
         S_ERR: begin
            lcd_display = 8'h10;
            status_led  = 4'b1000;
         end
         default: begin
            lcd_display = 8'h01;
            status_led  = 4'b0000;
         end
      endcase
      for (int i = 0; i < NUM_PRODUCTS; i++)
         stock_empty[i] = (stock_q[i] == '0);
   end

   assign credit        = credit_q;
   assign change_valid  = (state_q == S_CHG);
   assign change_amount = chg_q;
   assign coin_reject   = rej_q;

endmodule

// File: doc/vending_controller.md
Name: vending_controller

Overview:
Parametrised successor to the fixed four-product vending FSM. It supports N products, M coin denominations, per-product stock counters with a restock port, cancel/refund, a payment timeout and change return through a handshake. It sits between the front-panel input decoders (select, coin acceptor) and the dispense motors, LCD driver and status LEDs.

Parameters:
NUM_PRODUCTS, 4, number of products/motors (2..16)
NUM_COINS, 4, number of coin denominations (1..8)
CREDIT_W, 8, width of credit/price/coin values
STOCK_W, 4, width of per-product stock counter
PRICE_LIST, {8'd150,8'd100,8'd75,8'd50}, packed prices, product i at bits [i*CREDIT_W +: CREDIT_W]
COIN_LIST, {8'd100,8'd50,8'd20,8'd10}, packed coin values, same packing
TIMEOUT_CYCLES, 1000, idle cycles in PAYMENT before auto-refund (>=2)
INIT_STOCK, 5, stock of every product after reset

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
sel_valid  in  1  one-cycle product selection strobe
sel_index  in  clog2(NUM_PRODUCTS)  selected product
coin_valid  in  1  one-cycle coin strobe
coin_index  in  clog2(NUM_COINS)  coin denomination
cancel  in  1  refund request
item_dispensed  in  1  motor-complete sensor
change_ack  in  1  payout unit accepted change
restock_valid  in  1  restock strobe
restock_index  in  clog2(NUM_PRODUCTS)  product to restock
restock_qty  in  STOCK_W  quantity to add
lcd_display  out  8  one-hot state code
motor_control  out  NUM_PRODUCTS  one-hot motor drive
status_led  out  4  status indication
credit  out  CREDIT_W  current collected credit
change_valid  out  1  change_amount valid
change_amount  out  CREDIT_W  amount to return
coin_reject  out  1  one-cycle pulse: coin returned unaccepted
stock_empty  out  NUM_PRODUCTS  bit i set when stock[i]==0

Behaviour:
- Reset (async): state IDLE, credit 0, every stock counter INIT_STOCK, change_valid 0, change_amount 0, coin_reject 0, motor_control 0, lcd_display 8'h01, status_led 0. All outputs registered or decoded from registered state only.
- States and outputs (lcd/status_led): IDLE 01/0000; PAYMENT 04/0010; DISPENSE 08/0100; CHANGE 20/0001; ERROR 10/1000.
- IDLE: sel_valid with sel_index<NUM_PRODUCTS and stock>0 -> latch index, PAYMENT next cycle. Out-of-range index or stock==0 -> ERROR.
- ERROR: held 16 cycles, then IDLE. Credit is unchanged (always 0 here).
- PAYMENT: coin_valid adds COIN_LIST[coin_index] to credit; the sum saturates at 2^CREDIT_W-1. When the registered credit >= price, go to DISPENSE. The check uses the updated credit, so the coin that reaches the price moves to DISPENSE on the following edge. cancel -> CHANGE with change_amount=credit. Timeout counter resets on every coin and counts idle cycles; reaching TIMEOUT_CYCLES -> CHANGE with full credit (timeout with credit 0 -> IDLE). coin_valid and cancel in the same cycle: coin is accepted, then refunded with cancel. Out-of-range coin_index: coin_reject pulse, credit unchanged.
- DISPENSE: motor_control = 1<<latched index. On item_dispensed: stock[idx] decrements, motor off. Change = credit-price; nonzero -> CHANGE, zero -> IDLE; credit clears.
- CHANGE: change_valid=1 with change_amount stable until change_ack, then change_valid=0, credit=0, IDLE. change_ack while change_valid=0 is ignored.
- coin_valid in any state other than PAYMENT: coin_reject pulses 1 cycle, credit unchanged.
- Restock is accepted in any state. stock[idx] += qty, saturating at 2^STOCK_W-1. A restock of the product being dispensed in the same cycle as item_dispensed applies both: stock+qty-1, saturated.
- stock_empty is combinational from the stock registers.
- Reset mid-operation aborts the operation with no change output; credit is lost (documented operator behaviour).

Test Plan:
- Select product 1 (75); coins 50,20,10 -> credit 50,70,80; DISPENSE, motor_control=0010; item_dispensed -> change_valid, change_amount=5; change_ack -> IDLE, stock[1]=4.
- Select product 3 (150); coins 100,50 -> DISPENSE with change 0 -> IDLE directly, change_valid never asserted.
- Select product 2; coin 50; cancel -> CHANGE with change_amount=50; hold change_ack low 10 cycles, value stable; ack -> IDLE.
- Select product 0; coin 20; no activity for TIMEOUT_CYCLES -> CHANGE with 20. Separately, coin in IDLE -> coin_reject pulse, credit 0.
- Dispense product 0 five times -> stock_empty[0]=1; select 0 -> ERROR for 16 cycles, then IDLE. Restock 0 by 3 -> stock 3; restock 15 -> saturates at 15.
- Assert reset during DISPENSE with motor on -> outputs return to reset values immediately (async), stocks reload to 5.
